// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: result-source,
// forward-select codes and the memory wait-state FSM states.
package hazard_pkg;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic {
      RUN,
      MEMWAIT
   } state_e;

endpackage

// File: rtl/fwd_sel.sv
// Execute-stage operand forward select for one source register.
// A match in Memory is newer than one in Writeback, so it wins.
module fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] rs_e_i,
   input  logic [4:0] rd_m_i,
   input  logic       regwrite_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       regwrite_w_i,
   output logic [1:0] fwd_o
);

   always_comb begin
      fwd_o = FWD_RF;
      if (regwrite_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
         fwd_o = FWD_M;
      end else if (regwrite_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
         fwd_o = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward generation for the five-stage core, with a bounded
// memory wait-state FSM and saturating stall/flush performance counters.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       resultsrcE,
   input  logic             pcsrcE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             regwriteM,
   input  logic             regwriteW,
   input  logic             memreqM,
   input  logic             memackM,
   input  logic             clr_cnt,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushW,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             memerr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned      WC_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

   state_e                 state_q, state_d;
   logic [WC_W-1:0]        waitcnt_q, waitcnt_d;
   logic                   memerr_q, memerr_d;
   logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
   logic                   lwstall, mem_stall;
   logic [1:0]             fwd_a, fwd_b;

   fwd_sel u_fwd_a (
      .rs_e_i       (Rs1E),
      .rd_m_i       (RdM),
      .regwrite_m_i (regwriteM),
      .rd_w_i       (RdW),
      .regwrite_w_i (regwriteW),
      .fwd_o        (fwd_a)
   );

   fwd_sel u_fwd_b (
      .rs_e_i       (Rs2E),
      .rd_m_i       (RdM),
      .regwrite_m_i (regwriteM),
      .rd_w_i       (RdW),
      .regwrite_w_i (regwriteW),
      .fwd_o        (fwd_b)
   );

   // waitcnt is 0 in RUN, so the bound only bites once MEMWAIT has run its course
   assign lwstall   = (resultsrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
   assign mem_stall = memreqM && !memackM && (waitcnt_q < WC_MAX);

   // Controls are forced idle while reset is asserted, independent of inputs.
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
      if (rst) begin
         forwardAE = fwd_a;
         forwardBE = fwd_b;
         if (mem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (pcsrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (lwstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      waitcnt_d = waitcnt_q;
      memerr_d  = memerr_q;
      unique case (state_q)
         RUN: begin
            waitcnt_d = '0;
            if (memreqM && !memackM) begin
               state_d   = MEMWAIT;
               waitcnt_d = WC_W'(1);
            end
         end
         MEMWAIT: begin
            if (memackM || !memreqM) begin
               state_d   = RUN;
               waitcnt_d = '0;
            end else if (waitcnt_q < WC_MAX) begin
               waitcnt_d = waitcnt_q + WC_W'(1);
            end else begin
               state_d   = RUN;
               waitcnt_d = '0;
               memerr_d  = 1'b1;
            end
         end
         default: begin
            state_d   = RUN;
            waitcnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (flushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         waitcnt_q   <= '0;
         memerr_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         waitcnt_q   <= waitcnt_d;
         memerr_q    <= memerr_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign memerr    = memerr_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
